ysyx_25060170_exu_seq: RTL and testbench

//  Handshake sequencer for the EXU adder between IDU and WBU.
//  - Accepts one operation per valid/ready transfer from IDU.
//  - Holds the operands stable on the EXU inputs for ALU_LAT cycles, then captures the EXU result.
//  - Presents the result to WBU with valid/ready, and supports back-to-back issue and pipeline flush.

---
 rtl/ysyx_25060170_exu_seq.sv | 91 +++++++++
 tb/tb_ysyx_25060170_exu_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_exu_seq.sv
// rtl/ysyx_25060170_exu_seq.sv - valid/ready sequencer holding EXU operands for ALU_LAT cycles
module ysyx_25060170_exu_seq #(
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  input  logic             in_is_jalr,
  output logic [31:0]      exu_op1,
  output logic [31:0]      exu_op2,
  output logic             exu_is_jalr,
  input  logic [31:0]      exu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;

  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (lat_cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
    // A flush kills whatever is in flight; a DONE retire under flush still completes on the WBU side.
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exu_op1     <= '0;
      exu_op2     <= '0;
      exu_is_jalr <= 1'b0;
      lat_cnt     <= '0;
      out_res     <= '0;
      stall_cnt   <= '0;
    end else begin
      if (accept) begin
        exu_op1     <= in_op1;
        exu_op2     <= in_op2;
        exu_is_jalr <= in_is_jalr;
        lat_cnt     <= LAT_INIT;
      end else if (state == EXEC && !flush) begin
        if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
        else               out_res <= exu_res;
      end
      // Saturating so a long WBU stall never reads back as a small count.
      if (state == DONE && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_exu_seq.sv
// tb/tb_ysyx_25060170_exu_seq.sv - scoreboard bench for the EXU handshake sequencer
module tb_ysyx_25060170_exu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic        in_is_jalr = 1'b0;
  logic [31:0] exu_op1, exu_op2;
  logic        exu_is_jalr;
  logic [31:0] exu_res;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic        busy;
  logic [31:0] stall_cnt;

  ysyx_25060170_exu_seq #(.ALU_LAT(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_is_jalr(in_is_jalr),
    .exu_op1(exu_op1), .exu_op2(exu_op2), .exu_is_jalr(exu_is_jalr),
    .exu_res(exu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  // EXU adder model: sum, with the target LSB cleared for JALR
  assign exu_res = (exu_op1 + exu_op2) & ~{31'b0, exu_is_jalr};

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          retire_cyc[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res = '0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        jalr;
    logic [31:0] want;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor samples one time unit before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_res", out_res, prev_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_retire");
        else begin
          chk("retire_res", out_res, exp_q.pop_front());
          retire_cyc.push_back(cyc);
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_res  = out_res;
    end
  end

  // Leaves in_valid high on return, at the negedge following the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic j,
                       input logic [31:0] want);
    in_op1 = a; in_op2 = b; in_is_jalr = j; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        exp_q.push_back(want);
        @(negedge clk);
        return;
      end
      @(negedge clk);
      #1;
    end
    fail_now("issue_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    fail_now("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030};
    vecs[1] = '{32'h8000_0003, 32'h0000_0004, 1'b1, 32'h8000_0006};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789};
    vecs[4] = '{32'h0000_1000, 32'h0000_0005, 1'b1, 32'h0000_1004};
    vecs[5] = '{32'h0000_0007, 32'h0000_0008, 1'b0, 32'h0000_000F};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exu_op1", exu_op1, 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while an operation is in EXEC
    issue(32'd1, 32'd2, 1'b0, 32'd3);
    in_valid = 1'b0;
    #1;
    chk("midexec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_exu_op1", exu_op1, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operations with latency check
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      issue(vecs[k].op1, vecs[k].op2, vecs[k].jalr, vecs[k].want);
      in_valid = 1'b0;
      #1;
      chk("lat_exu_op1", exu_op1, vecs[k].op1);
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_valid_e1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid_e2", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid_e3", 32'(out_valid), 32'd1);
      chk("lat_res", out_res, vecs[k].want);
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
    end

    // Back-to-back with in_valid held high
    retire_cyc.delete();
    issue(32'd100, 32'd1, 1'b0, 32'd101);
    issue(32'd200, 32'd2, 1'b0, 32'd202);
    issue(32'd300, 32'd3, 1'b0, 32'd303);
    in_valid = 1'b0;
    wait_drain();
    chk("b2b_count", 32'(retire_cyc.size()), 32'd3);
    if (retire_cyc.size() == 3) begin
      chk("b2b_gap01", 32'(retire_cyc[1] - retire_cyc[0]), 32'd3);
      chk("b2b_gap12", 32'(retire_cyc[2] - retire_cyc[1]), 32'd3);
    end
    @(negedge clk);

    // Backpressure: five stalled cycles in DONE
    chk("pre_stall_cnt", stall_cnt, 32'd0);
    out_ready = 1'b0;
    issue(32'h100, 32'h23, 1'b0, 32'h123);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    chk("bp_stall_start", stall_cnt, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_res", out_res, 32'h123);
      @(negedge clk);
    end
    chk("bp_stall_cnt", stall_cnt, 32'd5);
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_stall_kept", stall_cnt, 32'd5);

    // Flush during EXEC kills the operation
    issue(32'd1, 32'd1, 1'b0, 32'd2);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_back());
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_no_valid", 32'(out_valid), 32'd0);
    end
    issue(32'd7, 32'd8, 1'b0, 32'd15);
    in_valid = 1'b0;
    wait_drain();
    @(negedge clk);

    // Flush in DONE with out_ready=1: retire happens, new accept suppressed
    issue(32'd5, 32'd6, 1'b0, 32'd11);
    in_op1 = 32'd9;
    in_op2 = 32'd9;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("fd_reach_done", 32'(out_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fd_busy", 32'(busy), 32'd0);
    chk("fd_exu_op1", exu_op1, 32'd5);
    chk("fd_retired", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
